// File: rtl/divider_pkg.sv
// divider_pkg: shared state encoding and constants for the restoring divider.
package divider_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  localparam logic [15:0] DZ_QUOTIENT = '1;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/borrow_subtractor.sv
// borrow_subtractor: combinational WIDTH+1-bit a - b built from a full-subtractor ripple chain.
module borrow_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic [WIDTH:0] diff,
  output logic           borrow
);
  logic [WIDTH+1:0] bc;
  assign bc[0] = 1'b0;
  for (genvar i = 0; i <= WIDTH; i++) begin : g_bit
    assign diff[i]  = a[i] ^ b[i] ^ bc[i];
    assign bc[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bc[i]);
  end
  assign borrow = bc[WIDTH+1];
endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
module restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  localparam int CW = cnt_w(WIDTH);
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] dsh_q, dsh_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH:0]   pshift, diff, p_next;
  logic [WIDTH-1:0] dsh_next;
  logic             borrow;
  // P never exceeds the divisor, so its top bit always drops out of the shift
  assign pshift   = (WIDTH+1)'({p_q, dsh_q[WIDTH-1]});
  assign p_next   = borrow ? pshift : diff;
  // the dividend shifts out the top while quotient bits fill in from the bottom
  assign dsh_next = {dsh_q[WIDTH-2:0], ~borrow};
  borrow_subtractor #(.WIDTH(WIDTH)) u_sub (
    .a      (pshift),
    .b      ({1'b0, dvs_q}),
    .diff   (diff),
    .borrow (borrow)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      p_q         <= '0;
      dsh_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      dsh_q       <= dsh_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    dsh_d       = dsh_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    case (state_q)
      IDLE: if (start) begin
        dvs_d      = divisor;
        div_zero_d = divisor == '0;
        if (divisor == '0) begin
          state_d     = DONE;
          quotient_d  = WIDTH'(DZ_QUOTIENT);
          remainder_d = dividend;
        end else begin
          state_d = RUN;
          p_d     = '0;
          dsh_d   = dividend;
          cnt_d   = '0;
        end
      end
      RUN: begin
        p_d   = p_next;
        dsh_d = dsh_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d     = DONE;
          quotient_d  = dsh_next;
          remainder_d = p_next[WIDTH-1:0];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: directed plus randomized checks of the divider against an arithmetic model.
module tb_restoring_divider;
  localparam int W = 4;
  logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] quotient, remainder;
  logic [W:0]   sa, sb, sd;
  logic         sbo;
  int           compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  restoring_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  borrow_subtractor #(.WIDTH(W)) u_sub (
    .a      (sa),
    .b      (sb),
    .diff   (sd),
    .borrow (sbo)
  );

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Entered and left at a falling edge; hold=1 keeps requesting 9/9 while busy.
  task automatic run_div(input int a, input int b, input bit hold);
    int cyc, bcnt, eq, er, lat;
    eq  = (b == 0) ? (1 << W) - 1 : a / b;
    er  = (b == 0) ? a : a % b;
    lat = (b == 0) ? 0 : W;
    start = 1'b1; dividend = W'(a); divisor = W'(b);
    @(posedge clk);
    cyc = 0; bcnt = 0;
    @(negedge clk);
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      start    = hold;
      dividend = hold ? W'(9) : W'($urandom);
      divisor  = hold ? W'(9) : W'($urandom);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    if (busy) bcnt++;
    check($sformatf("done_latency %0d/%0d", a, b), cyc, lat);
    check($sformatf("busy_cycles %0d/%0d", a, b), bcnt, lat + 1);
    check($sformatf("quotient %0d/%0d", a, b), int'(quotient), eq);
    check($sformatf("remainder %0d/%0d", a, b), int'(remainder), er);
    check($sformatf("div_zero %0d/%0d", a, b), int'(div_zero), int'(b == 0));
    start = hold;
    @(posedge clk);
    @(negedge clk);
    check($sformatf("done_pulse_end %0d/%0d", a, b), int'(done), 0);
    check($sformatf("idle_busy %0d/%0d", a, b), int'(busy), 0);
    check($sformatf("hold_quotient %0d/%0d", a, b), int'(quotient), eq);
    check($sformatf("hold_remainder %0d/%0d", a, b), int'(remainder), er);
  endtask

  initial begin
    int ra, rb, seen;
    for (int i = 0; i < 20; i++) begin
      ra = $urandom_range(0, 31);
      rb = $urandom_range(0, 31);
      sa = 5'(ra); sb = 5'(rb);
      #1;
      check("sub_diff", int'(sd), (ra - rb) & 31);
      check("sub_borrow", int'(sbo), int'(ra < rb));
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_quotient", int'(quotient), 0);
    check("reset_remainder", int'(remainder), 0);
    check("reset_div_zero", int'(div_zero), 0);

    run_div(13, 3, 1'b0);
    run_div(15, 1, 1'b0);
    run_div(2, 9, 1'b0);
    run_div(7, 0, 1'b0);
    run_div(8, 2, 1'b0);
    run_div(12, 5, 1'b1);
    run_div(9, 9, 1'b0);

    start = 1'b1; dividend = 4'd14; divisor = 4'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_quotient", int'(quotient), 0);
    check("midrst_remainder", int'(remainder), 0);
    check("midrst_div_zero", int'(div_zero), 0);
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (done) seen++;
    end
    check("midrst_no_done", seen, 0);
    run_div(14, 4, 1'b0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_div(a, b, 1'b0);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_div(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
